// File: rtl/bcd_stopwatch.sv
// BCD stopwatch MM:SS.T counting prescaled tick pulses, with run/pause,
// clear and lap-freeze controls. All outputs are registered.
module bcd_stopwatch #(
    parameter int unsigned TICKS_PER_TENTH = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic       timer_en,
    output logic       running,
    output logic       lap_active,
    output logic       overflow,
    output logic [3:0] tenths,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam logic [7:0] PRE_MAX = 8'(TICKS_PER_TENTH - 1);

    // Count vectors are packed {min_tens, min_ones, sec_tens, sec_ones, tenths}.
    // Returns {wrap, next}; wrap marks the 59:59.9 -> 00:00.0 rollover.
    function automatic logic [20:0] bcd_inc(input logic [19:0] c);
        logic [3:0] d0, d1, d2, d3, d4;
        logic       wrap;
        {d4, d3, d2, d1, d0} = c;
        wrap = 1'b0;
        if (d0 != 4'd9) begin
            d0 = d0 + 4'd1;
        end else begin
            d0 = 4'd0;
            if (d1 != 4'd9) begin
                d1 = d1 + 4'd1;
            end else begin
                d1 = 4'd0;
                if (d2 != 4'd5) begin
                    d2 = d2 + 4'd1;
                end else begin
                    d2 = 4'd0;
                    if (d3 != 4'd9) begin
                        d3 = d3 + 4'd1;
                    end else begin
                        d3 = 4'd0;
                        if (d4 != 4'd5) begin
                            d4 = d4 + 4'd1;
                        end else begin
                            d4   = 4'd0;
                            wrap = 1'b1;
                        end
                    end
                end
            end
        end
        return {wrap, d4, d3, d2, d1, d0};
    endfunction

    state_t      state_r, state_s;
    logic [19:0] live_r, live_s;
    logic [19:0] lap_r, lap_s;
    logic [7:0]  pre_r, pre_s;
    logic        ovf_r, ovf_s;
    logic [20:0] inc_s;
    logic [19:0] disp_r;
    logic        timer_en_r, running_r, lap_active_r;

    // Next-state, counting and lap-capture logic for one clock cycle.
    always_comb begin
        state_s = state_r;
        live_s  = live_r;
        lap_s   = lap_r;
        pre_s   = pre_r;
        ovf_s   = ovf_r;
        inc_s   = bcd_inc(live_r);

        // Ticks count only in the state held at the start of the cycle.
        if (tick && (state_r == ST_RUN || state_r == ST_LAP)) begin
            if (pre_r == PRE_MAX) begin
                pre_s  = 8'd0;
                live_s = inc_s[19:0];
                ovf_s  = ovf_r | inc_s[20];
            end else begin
                pre_s = pre_r + 8'd1;
            end
        end else begin
            pre_s = pre_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start_stop) state_s = ST_RUN;
                else            state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (start_stop) begin
                    state_s = ST_PAUSE;
                end else if (lap) begin
                    state_s = ST_LAP;
                    lap_s   = live_r;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_LAP: begin
                if (start_stop) state_s = ST_PAUSE;
                else if (lap)   state_s = ST_RUN;
                else            state_s = ST_LAP;
            end
            ST_PAUSE: begin
                if (clear) begin
                    state_s = ST_IDLE;
                    live_s  = 20'd0;
                    pre_s   = 8'd0;
                    ovf_s   = 1'b0;
                end else if (start_stop) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, count registers and registered output decode.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            live_r       <= 20'd0;
            lap_r        <= 20'd0;
            pre_r        <= 8'd0;
            ovf_r        <= 1'b0;
            disp_r       <= 20'd0;
            timer_en_r   <= 1'b0;
            running_r    <= 1'b0;
            lap_active_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            live_r       <= live_s;
            lap_r        <= lap_s;
            pre_r        <= pre_s;
            ovf_r        <= ovf_s;
            disp_r       <= (state_s == ST_LAP) ? lap_s : live_s;
            timer_en_r   <= (state_s == ST_RUN) || (state_s == ST_LAP);
            running_r    <= (state_s == ST_RUN) || (state_s == ST_LAP);
            lap_active_r <= (state_s == ST_LAP);
        end
    end

    assign timer_en   = timer_en_r;
    assign running    = running_r;
    assign lap_active = lap_active_r;
    assign overflow   = ovf_r;
    assign {min_tens, min_ones, sec_tens, sec_ones, tenths} = disp_r;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: two instances (1 and 2 ticks per tenth) driven by
// the same stimulus and checked each cycle against a tenths-counting model.
module tb_bcd_stopwatch;

    logic clk = 1'b0;
    logic reset_n = 1'b0, tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;

    logic       a_en, a_run, a_la, a_ov;
    logic [3:0] a_t, a_so, a_st, a_mo, a_mt;
    logic       b_en, b_run, b_la, b_ov;
    logic [3:0] b_t, b_so, b_st, b_mo, b_mt;

    always #5 clk = ~clk;

    bcd_stopwatch #(.TICKS_PER_TENTH(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap), .timer_en(a_en), .running(a_run),
        .lap_active(a_la), .overflow(a_ov), .tenths(a_t), .sec_ones(a_so),
        .sec_tens(a_st), .min_ones(a_mo), .min_tens(a_mt));

    bcd_stopwatch #(.TICKS_PER_TENTH(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap), .timer_en(b_en), .running(b_run),
        .lap_active(b_la), .overflow(b_ov), .tenths(b_t), .sec_ones(b_so),
        .sec_tens(b_st), .min_ones(b_mo), .min_tens(b_mt));

    wire [19:0] a_disp = {a_mt, a_mo, a_st, a_so, a_t};
    wire [19:0] b_disp = {b_mt, b_mo, b_st, b_so, b_t};

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: elapsed tenths as a plain integer.
    typedef enum int {M_IDLE, M_RUN, M_LAP, M_PAUSE} mstate_t;
    mstate_t m_st[2];
    int      m_cnt[2], m_lapcnt[2], m_pre[2], m_ovf[2];
    int      tpt[2] = '{1, 2};

    function automatic logic [19:0] to_bcd(input int n);
        int mins, secs;
        mins = n / 600;
        secs = (n / 10) % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), 4'(n % 10)};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int old_cnt;
        old_cnt = m_cnt[k];
        if (tick && (m_st[k] == M_RUN || m_st[k] == M_LAP)) begin
            m_pre[k]++;
            if (m_pre[k] == tpt[k]) begin
                m_pre[k] = 0;
                m_cnt[k]++;
                if (m_cnt[k] == 36000) begin
                    m_cnt[k] = 0;
                    m_ovf[k] = 1;
                end
            end
        end
        case (m_st[k])
            M_IDLE:  if (start_stop) m_st[k] = M_RUN;
            M_RUN:   if (start_stop) m_st[k] = M_PAUSE;
                     else if (lap) begin m_st[k] = M_LAP; m_lapcnt[k] = old_cnt; end
            M_LAP:   if (start_stop) m_st[k] = M_PAUSE;
                     else if (lap) m_st[k] = M_RUN;
            M_PAUSE: if (clear) begin
                         m_st[k] = M_IDLE; m_cnt[k] = 0; m_pre[k] = 0; m_ovf[k] = 0;
                     end else if (start_stop) m_st[k] = M_RUN;
            default: m_st[k] = M_IDLE;
        endcase
        if (!reset_n) begin
            m_st[k] = M_IDLE; m_cnt[k] = 0; m_lapcnt[k] = 0; m_pre[k] = 0; m_ovf[k] = 0;
        end
    endtask

    function automatic logic [23:0] model_out(input int k);
        logic act;
        act = (m_st[k] == M_RUN || m_st[k] == M_LAP);
        return {to_bcd(m_st[k] == M_LAP ? m_lapcnt[k] : m_cnt[k]),
                act, act, m_st[k] == M_LAP, m_ovf[k] != 0};
    endfunction

    task automatic drive(input logic r, input logic t, input logic s, input logic c, input logic l);
        reset_n = r; tick = t; start_stop = s; clear = c; lap = l;
    endtask

    // One clock: update model at the edge, compare both instances 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cmp("model_tpt1", {8'd0, a_disp, a_en, a_run, a_la, a_ov}, {8'd0, model_out(0)});
        cmp("model_tpt2", {8'd0, b_disp, b_en, b_run, b_la, b_ov}, {8'd0, model_out(1)});
    endtask

    typedef struct {
        logic r, t, s, c, l;
        logic [19:0] disp;
        logic run, la, ov;
    } vec_t;

    vec_t vecs[21];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_st[k] = M_IDLE; m_cnt[k] = 0; m_lapcnt[k] = 0; m_pre[k] = 0; m_ovf[k] = 0;
        end

        // Expected values are for the 2-ticks-per-tenth instance.
        //           r     t     s     c     l     disp       run   la    ov
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00001, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00001, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 20'h00001, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00001, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00001, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00003, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00003, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00003, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00003, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00004, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'h00004, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00004, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00004, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0};

        #2;
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].r, vecs[i].t, vecs[i].s, vecs[i].c, vecs[i].l);
            step();
            cmp($sformatf("vec%0d", i), {8'd0, b_disp, b_en, b_run, b_la, b_ov},
                {8'd0, vecs[i].disp, vecs[i].run, vecs[i].run, vecs[i].la, vecs[i].ov});
        end

        // Stop on 00:01.0 with 2 ticks per tenth, then confirm ticks are ignored.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
        for (int i = 0; i < 20; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step(); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
        cmp("run_10s_disp", {12'd0, b_disp}, {12'd0, 20'h00010});
        cmp("run_10s_flags", {30'd0, b_en, b_run}, {30'd0, 1'b1, 1'b1});
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
        cmp("stop_running", {31'd0, b_run}, 32'd0);
        for (int i = 0; i < 6; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step(); end
        cmp("paused_hold", {12'd0, b_disp}, {12'd0, 20'h00010});

        // Full-range count and wrap with 1 tick per tenth.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
        for (int i = 0; i < 35999; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step(); end
        cmp("max_disp", {12'd0, a_disp}, {12'd0, 20'h59599});
        cmp("max_ovf", {31'd0, a_ov}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
        cmp("wrap_disp", {12'd0, a_disp}, 32'd0);
        cmp("wrap_ovf", {31'd0, a_ov}, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); step();
        cmp("clear_ovf", {31'd0, a_ov}, 32'd0);

        // Lap freeze at 00:01.2 with 2 ticks per tenth, then release at 00:01.7.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
        for (int i = 0; i < 24; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step(); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); step();
        for (int i = 0; i < 10; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step(); end
        cmp("lap_frozen", {11'd0, b_disp, b_la}, {11'd0, 20'h00012, 1'b1});
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); step();
        cmp("lap_release", {11'd0, b_disp, b_la}, {11'd0, 20'h00017, 1'b0});

        // Reset while in LAP at 00:02.4.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
        for (int i = 0; i < 48; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step(); end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); step();
        cmp("lap_024", {11'd0, b_disp, b_la}, {11'd0, 20'h00024, 1'b1});
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1); step();
        cmp("reset_in_lap", {9'd0, b_disp, b_en, b_run, b_la}, 32'd0);

        // Random pulses against the model.
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
